// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_rd_pkg;

    // Width of the issue counter and of the captured-word counter.
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rd_valid_pipe.sv
// Delay line that tracks outstanding FIFO reads until their data is on rd_data.
// Latency: RD_LAT cycles from vld to cap_en.
// Backpressure: none; every request entered is carried through unless reset.
//
// Ports: clk, rst (sync, active-high), vld (read issued this cycle),
//        cap_en (data for an earlier read is on the FIFO output now),
//        empty (no reads in flight).
module rd_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    output logic cap_en,
    output logic empty
);

    logic [RD_LAT-1:0] vld_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign cap_en = vld_sr[RD_LAT-1];
    assign empty  = ~|vld_sr;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a non-show-ahead FIFO: waits for full/level, bursts, re-times data.
// Latency: word requested at edge N is on dout with dout_valid at edge N+RD_LAT.
// Backpressure: none downstream; rdreq is withheld while the FIFO is empty or enable is low.
//
// Ports: clk, rst (sync, active-high), enable (arm; low aborts a burst),
//        rd_full/rd_empty/rd_usedw/rd_data (FIFO read side), rdreq (FIFO read request),
//        dout/dout_valid (captured word strobe), word_cnt (words of current/last burst),
//        busy (READ or DRAIN), burst_done/burst_abort (end-of-burst pulse and cause).
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W        = 9,
    parameter int USEDW_W       = 8,
    parameter int START_ON_FULL = 1,
    parameter int START_LVL     = 128,
    parameter int BURST_LEN     = 0,
    parameter int RD_LAT        = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               rd_full,
    input  logic               rd_empty,
    input  logic [USEDW_W-1:0] rd_usedw,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               rdreq,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic [CNT_W-1:0]   word_cnt,
    output logic               busy,
    output logic               burst_done,
    output logic               burst_abort
);

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);
    // One extra bit so a threshold equal to the full depth is still representable.
    localparam logic [USEDW_W:0] LVL_C   = (USEDW_W+1)'(START_LVL);

    rd_state_t        state;
    logic [CNT_W-1:0] issue_cnt;
    logic             abort_flag;
    logic             start_cond;
    logic             start;
    logic             last_issued;
    logic             cap_en;
    logic             pipe_empty;

    assign start_cond  = (START_ON_FULL != 0) ? rd_full : ({1'b0, rd_usedw} >= LVL_C);
    assign start       = (state == IDLE) && enable && start_cond;
    assign last_issued = (BURST_LEN > 0) && (issue_cnt >= BURST_C);

    // Combinational so a read never lands on a cycle where the FIFO reports empty.
    assign rdreq = (state == READ) && enable && !rd_empty && !last_issued;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            abort_flag  <= 1'b0;
            burst_done  <= 1'b0;
            burst_abort <= 1'b0;
        end else begin
            burst_done  <= 1'b0;
            burst_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= READ;
                        issue_cnt  <= '0;
                        abort_flag <= 1'b0;
                    end
                end
                READ: begin
                    if (rdreq) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (!enable) begin
                        state      <= DRAIN;
                        abort_flag <= 1'b1;
                    end else if (BURST_LEN == 0) begin
                        // Drain-until-empty: empty is judged before any read this cycle.
                        if (rd_empty) begin
                            state <= DRAIN;
                        end
                    end else if (rdreq && ((issue_cnt + CNT_W'(1)) == BURST_C)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave only once every issued read has been captured.
                    if (pipe_empty) begin
                        state       <= IDLE;
                        burst_done  <= 1'b1;
                        burst_abort <= abort_flag;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_valid_pipe (
        .clk    (clk),
        .rst    (rst),
        .vld    (rdreq),
        .cap_en (cap_en),
        .empty  (pipe_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            word_cnt   <= '0;
        end else begin
            dout_valid <= cap_en;
            if (cap_en) begin
                dout <= rd_data;
                if (word_cnt != '1) begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end
            // Pipe is always empty in IDLE, so this never collides with a capture.
            if (start) begin
                word_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: four configurations, each fed by its own behavioural FIFO.
// Inst 0: full-start, drain-until-empty, RD_LAT=1.  Inst 1: level 16, burst 8, RD_LAT=1.
// Inst 2: level 4, burst 4, RD_LAT=2.               Inst 3: level 10, burst 10, RD_LAT=1.
module tb_fifo_rd_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst, enable, wr, ovr;
    logic [N-1:0][8:0]  wdata;
    logic [N-1:0]       rd_full, rd_empty, rdreq, dout_valid, busy, burst_done, burst_abort;
    logic [N-1:0][7:0]  rd_usedw;
    logic [N-1:0][8:0]  rd_data, dout;
    logic [N-1:0][15:0] word_cnt;

    // Behavioural FIFOs (one per instance); q1 is 1-cycle read data, q2 is 2-cycle.
    logic [8:0]        mem [N][256];
    logic [N-1:0][7:0] wp   = '0;
    logic [N-1:0][7:0] rp   = '0;
    logic [N-1:0][8:0] fcnt = '0;
    logic [N-1:0][8:0] q1   = '0;
    logic [N-1:0][8:0] q2   = '0;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (wr[k]) begin
                mem[k][wp[k]] <= wdata[k];
                wp[k]         <= wp[k] + 8'd1;
            end
            if (rdreq[k]) begin
                q1[k] <= mem[k][rp[k]];
                rp[k] <= rp[k] + 8'd1;
            end
            q2[k]   <= q1[k];
            fcnt[k] <= fcnt[k] + 9'(wr[k]) - 9'(rdreq[k]);
        end
    end

    for (genvar k = 0; k < N; k++) begin : g
        assign rd_empty[k] = (fcnt[k] == 9'd0);
        assign rd_full[k]  = (fcnt[k] == 9'd256);
        assign rd_usedw[k] = ovr[k] ? 8'hFF : fcnt[k][7:0];
        assign rd_data[k]  = (k == 2) ? q2[k] : q1[k];

        fifo_rd_ctrl #(
            .DATA_W        (9),
            .USEDW_W       (8),
            .START_ON_FULL ((k == 0) ? 1 : 0),
            .START_LVL     ((k == 1) ? 16 : ((k == 2) ? 4 : 10)),
            .BURST_LEN     ((k == 0) ? 0 : ((k == 1) ? 8 : ((k == 2) ? 4 : 10))),
            .RD_LAT        ((k == 2) ? 2 : 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[k]),
            .enable      (enable[k]),
            .rd_full     (rd_full[k]),
            .rd_empty    (rd_empty[k]),
            .rd_usedw    (rd_usedw[k]),
            .rd_data     (rd_data[k]),
            .rdreq       (rdreq[k]),
            .dout        (dout[k]),
            .dout_valid  (dout_valid[k]),
            .word_cnt    (word_cnt[k]),
            .busy        (busy[k]),
            .burst_done  (burst_done[k]),
            .burst_abort (burst_abort[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    // Scoreboard
    typedef struct { int inst; logic [8:0] dat; } wexp_t;
    typedef struct { int inst; int cnt; bit abort; int nreq; int left; } bexp_t;

    wexp_t wq [$];
    bexp_t bq [$];

    int n_chk = 0;
    int n_pass = 0;
    int tmo_req = 0;
    int tmo_seen = 0;
    bit fin_req = 1'b0;
    bit fin_done = 1'b0;

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", nm, k, act, exp);
    endtask

    // Monitor: everything compared at the falling edge, away from DUT updates.
    initial begin
        logic [N-1:0]      rst_d;
        logic [N-1:0][2:0] hist;
        int                reqn [N];
        wexp_t             e;
        bexp_t             b;
        bit                exp_v;
        rst_d = '0;
        hist  = '0;
        for (int k = 0; k < N; k++) reqn[k] = 0;
        forever begin
            @(negedge clk);
            if (tmo_req != tmo_seen) begin
                check("burst_done_timeout", 0, 32'(tmo_req), 32'(tmo_seen));
                tmo_seen = tmo_req;
            end
            for (int k = 0; k < N; k++) begin
                if (rst_d[k])
                    check("reset_outputs", k,
                          32'({rdreq[k], dout[k], dout_valid[k], word_cnt[k],
                               busy[k], burst_done[k], burst_abort[k]}), 32'd0);
                // rdreq seen here is taken at the next edge; its strobe shows RD_LAT+1 falls later.
                exp_v = hist[k][lat_of(k)];
                if (dout_valid[k] !== 1'b0 || exp_v)
                    check("valid_latency", k, 32'(dout_valid[k]), 32'(exp_v));
                if (dout_valid[k] === 1'b1) begin
                    if (wq.size() == 0) begin
                        check("unexpected_word", k, 32'(dout[k]), 32'hFFFF_FFFF);
                    end else begin
                        e = wq.pop_front();
                        check("dout_word", k, {7'd0, 16'(k), dout[k]}, {7'd0, 16'(e.inst), e.dat});
                    end
                end
                if (rdreq[k] === 1'b1)
                    check("rdreq_while_empty", k, 32'(rd_empty[k]), 32'd0);
                if (burst_done[k] === 1'b1) begin
                    if (bq.size() == 0) begin
                        check("unexpected_burst_done", k, 32'(burst_done[k]), 32'd0);
                    end else begin
                        b = bq.pop_front();
                        check("done_inst", k, 32'(k), 32'(b.inst));
                        check("word_cnt", k, 32'(word_cnt[k]), 32'(b.cnt));
                        check("burst_abort", k, 32'(burst_abort[k]), 32'(b.abort));
                        check("rdreq_count", k, 32'(reqn[k]), 32'(b.nreq));
                        check("fifo_level_after", k, 32'(fcnt[k]), 32'(b.left));
                        check("busy_at_done", k, 32'(busy[k]), 32'd0);
                        check("words_pending_at_done", k, 32'(wq.size()), 32'd0);
                    end
                    reqn[k] = 0;
                end
                if (rst[k]) reqn[k] = 0;
                else if (rdreq[k] === 1'b1) reqn[k] = reqn[k] + 1;
                hist[k]  = rst[k] ? 3'b000 : {hist[k][1:0], (rdreq[k] === 1'b1)};
                rst_d[k] = rst[k];
            end
            if (fin_req && !fin_done) begin
                check("words_left_at_end", 0, 32'(wq.size()), 32'd0);
                check("bursts_left_at_end", 0, 32'(bq.size()), 32'd0);
                fin_done = 1'b1;
            end
        end
    end

    // Stimulus
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int k, input int d);
        wexp_t e;
        e.inst = k;
        e.dat  = 9'(d);
        wq.push_back(e);
    endtask

    task automatic fill(input int k, input int n, input int base, input int nexp);
        for (int i = 0; i < n; i++) begin
            wr[k]    = 1'b1;
            wdata[k] = 9'(base + i);
            if (i < nexp) expect_word(k, base + i);
            cyc(1);
        end
        wr[k] = 1'b0;
    endtask

    task automatic expect_burst(input int k, input int cnt, input bit ab, input int nreq, input int left);
        bexp_t b;
        b.inst  = k;
        b.cnt   = cnt;
        b.abort = ab;
        b.nreq  = nreq;
        b.left  = left;
        bq.push_back(b);
    endtask

    task automatic wait_done(input int k, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc(1);
            if (burst_done[k] === 1'b1) seen = 1'b1;
        end
        if (!seen) tmo_req++;
        cyc(2);
    endtask

    initial begin
        rst    = '1;
        enable = '0;
        wr     = '0;
        ovr    = '0;
        wdata  = '0;
        cyc(3);
        rst = '0;
        cyc(2);

        // Full FIFO drained completely.
        fill(0, 256, 0, 256);
        expect_burst(0, 256, 1'b0, 256, 0);
        enable[0] = 1'b1;
        wait_done(0, 400);
        enable[0] = 1'b0;

        // Level start at 16, fixed 8-word burst leaves 8 behind.
        enable[1] = 1'b1;
        expect_burst(1, 8, 1'b0, 8, 8);
        fill(1, 16, 100, 8);
        wait_done(1, 100);

        // Forced start to take the remaining 8.
        for (int i = 0; i < 8; i++) expect_word(1, 108 + i);
        expect_burst(1, 8, 1'b0, 8, 0);
        ovr[1] = 1'b1;
        cyc(2);
        ovr[1] = 1'b0;
        wait_done(1, 50);

        // 8-word burst against 5 words: pause on empty, resume after 3 more.
        fill(1, 5, 200, 5);
        expect_burst(1, 8, 1'b0, 8, 0);
        ovr[1] = 1'b1;
        cyc(2);
        ovr[1] = 1'b0;
        cyc(10);
        fill(1, 3, 205, 3);
        wait_done(1, 50);
        enable[1] = 1'b0;

        // Two-cycle read latency, 4-word burst.
        fill(2, 4, 300, 4);
        expect_burst(2, 4, 1'b0, 4, 0);
        enable[2] = 1'b1;
        wait_done(2, 50);
        enable[2] = 1'b0;

        // Abort after three reads of a 10-word burst.
        fill(3, 10, 400, 3);
        expect_burst(3, 3, 1'b1, 3, 7);
        enable[3] = 1'b1;
        cyc(4);
        enable[3] = 1'b0;
        wait_done(3, 50);

        // Reset with two reads in flight on the two-cycle instance: nothing may emerge.
        fill(2, 4, 310, 0);
        enable[2] = 1'b1;
        cyc(3);
        rst[2]    = 1'b1;
        enable[2] = 1'b0;
        cyc(1);
        rst[2] = 1'b0;
        cyc(6);

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) cyc(1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
